// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter and receiver
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  localparam int DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam int CNT_W = 12;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: BIT_TICKS-period counter with sync clear and a bit_end pulse
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int BIT_TICKS = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic bit_end
);
  logic [CNT_W-1:0] cnt;
  assign bit_end = en && cnt == CNT_W'(BIT_TICKS - 1);
  // count ticks within a bit, wrapping to 0 on the last tick
  always_ff @(posedge clk)
    cnt <= clr ? '0 : bit_end ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: double-buffered 8N1/8N2 serial transmitter
module uart_tx
  import uart_pkg::*;
#(
  parameter int BIT_TICKS = 16,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  input  logic       oe_clr,
  output logic       TxD,
  output logic       tdre,
  output logic       tx_busy,
  output logic       OE
);
  uart_state_t state, state_n;
  logic [DATA_BITS-1:0] hold, shift, shift_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic bit_end, last_bit, last_stop, transfer, txd_n;
  assign last_bit = bit_cnt == 4'(DATA_BITS - 1);
  assign last_stop = bit_cnt == 4'(STOP_BITS - 1);
  assign transfer = !tdre && (state == IDLE || (state == STOP && bit_end && last_stop));
  assign tx_busy = state != IDLE;
  uart_bit_timer #(.BIT_TICKS(BIT_TICKS)) timer (
    .clk(clk),
    .clr(clr || transfer),
    .en(state != IDLE),
    .bit_end(bit_end)
  );
  // holding register, empty flag and sticky overrun (a new overrun beats oe_clr)
  always_ff @(posedge clk) begin
    if (clr) begin
      hold <= '0;
      tdre <= 1'b1;
      OE <= 1'b0;
    end else begin
      hold <= (tx_load && tdre) ? tx_data : hold;
      tdre <= transfer ? 1'b1 : tx_load ? 1'b0 : tdre;
      OE <= (tx_load && !tdre) || (OE && !oe_clr);
    end
  end
  // state, shifter, bit counter and the registered line output
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      shift <= '0;
      bit_cnt <= '0;
      TxD <= LINE_IDLE;
    end else begin
      state <= state_n;
      shift <= shift_n;
      bit_cnt <= bit_cnt_n;
      TxD <= txd_n;
    end
  end
  // next state plus shifter/bit-counter updates at bit boundaries
  always_comb begin
    state_n = state == IDLE  ? (transfer ? START : IDLE)
            : state == START ? (bit_end ? DATA : START)
            : state == DATA  ? (bit_end && last_bit ? STOP : DATA)
            : bit_end && last_stop ? (transfer ? START : IDLE) : STOP;
    shift_n = transfer ? hold : (state == DATA && bit_end) ? shift >> 1 : shift;
    bit_cnt_n = transfer ? 4'd0
              : (!bit_end || state == START) ? bit_cnt
              : ((state == DATA && last_bit) || (state == STOP && last_stop)) ? 4'd0
              : bit_cnt + 4'd1;
  end
  // line level for the coming cycle, so TxD only moves on bit boundaries
  always_comb
    txd_n = state_n == START ? START_LEVEL : state_n == DATA ? shift_n[0] : LINE_IDLE;
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter for the team's UART link: 8 data bits, LSB first, no parity, 1 or 2 stop bits.
- Frame format and bit timing match the UART receiver block, so a looped TxD→RxD path returns the same byte.
- Double-buffered: one holding register plus one shift register, so the CPU/bus side can queue the next byte while the current frame is on the wire.
- Sits between the bus-side write logic and the TxD pad.

Parameters:
- BIT_TICKS, 16, clk cycles per serial bit (legal range 2..4095); the bit counter is 12 bits wide.
- STOP_BITS, 1, number of stop bits (legal values 1 or 2).

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- clr  input  1  reset, synchronous, active-high.
- tx_data  input  8  byte to send; sampled only when tx_load=1 and tdre=1.
- tx_load  input  1  write strobe, one cycle wide.
- oe_clr  input  1  clears OE.
- TxD  output  1  serial line; idles high.
- tdre  output  1  transmit data register (holding register) empty.
- tx_busy  output  1  high while a frame is being shifted out.
- OE  output  1  overrun error; sticky.

Behaviour:
- Reset (clr=1 at a clk edge), taking effect on that edge:
  - TxD=1, tdre=1, tx_busy=0, OE=0.
  - State=IDLE; bit and baud counters=0; both registers=0.
  - A reset mid-frame aborts the frame immediately and TxD returns high. No partial byte is resumed.
- Load:
  - If tx_load=1 and tdre=1 at edge n: holding register <= tx_data, and tdre=0 from n+1.
  - If tx_load=1 and tdre=0: the data is dropped, the holding register is unchanged, and OE=1 from the next cycle.
  - OE stays set until oe_clr=1 or clr. If oe_clr and a new overrun occur in the same cycle, OE stays 1 (set wins).
- Transfer: in IDLE, or on the last cycle of the final stop bit, with tdre=0:
  - shift register <= holding register;
  - tdre=1 and tx_busy=1 on the next cycle;
  - state=START.
- State machine:
  - IDLE: TxD=1, tx_busy=0. Wait for transfer.
  - START: TxD=0 for BIT_TICKS cycles, then go to DATA.
  - DATA: TxD=shift[0] for BIT_TICKS cycles. At the end of each bit, shift right and increment the bit counter. After the 8th bit, go to STOP.
  - STOP: TxD=1 for STOP_BITS*BIT_TICKS cycles. Then:
    - holding full: transfer and go to START (back-to-back frames, no idle gap);
    - otherwise: go to IDLE.
- Latency and timing:
  - tx_load at edge n with the link idle: tdre=0 at n+1, transfer at n+1, TxD falls at n+2, tdre=1 again at n+2.
  - Frame length is exactly (9+STOP_BITS)*BIT_TICKS cycles.
  - TxD is a registered output (no combinational path from inputs).
- Baud counter: counts 0..BIT_TICKS-1 and wraps to 0 at each bit boundary. It resets to 0 on transfer.
- Simultaneous events:
  - tx_load in the same cycle as transfer cannot collide: transfer requires tdre=0, and load requires tdre=1.
  - A load in the cycle after transfer is accepted normally.
- TxD never glitches: it changes only at bit boundaries or on reset.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP; 2-bit encoding);
  - DATA_BITS=8;
  - LINE_IDLE=1'b1 and START_LEVEL=1'b0;
  - the counter width constant (12 bits).
- The receiver also moves to this package.
- One natural sub-module: uart_bit_timer, a BIT_TICKS-period counter with sync clear and a bit_end pulse. It is shared with the receiver.

Test Plan (BIT_TICKS=4, STOP_BITS=1 unless stated):
- Reset then idle 50 cycles -> TxD=1, tdre=1, tx_busy=0, OE=0 throughout.
- Load 8'hA5 -> TxD sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, 40 cycles total. tdre falls for one cycle and rises 2 cycles after the load. tx_busy is high exactly 40 cycles.
- Load 8'h3C, then load 8'h81 when tdre rises -> the second start bit begins immediately after the first stop bit (no idle cycle). A loopback receiver gets 3C then 81.
- Load 8'h11, then 8'h22 (accepted), then 8'h33 while tdre=0 -> OE=1, 33 never appears on TxD. oe_clr pulse -> OE=0.
- clr asserted during data bit 3 of 8'hFF -> TxD=1 on the next cycle, tdre=1. A new load of 8'h00 then sends a clean full frame.
- STOP_BITS=2, load 8'h55 -> stop held high 8 cycles, frame length 44 cycles.
